// File: rtl/xilinx_exit_status_uart_tx.sv
// Watches the SoC exit-status handshake and reports each exit value to the
// host as the ASCII line "EXIT=XXXXXXXX\r\n" on an 8N1 UART transmitter.
//   clk_gen       : system clock
//   rst_n         : asynchronous active-low reset
//   exit_valid_i  : exit-valid level; a rising edge captures exit_value_i
//   exit_value_i  : 32-bit exit value
//   tx_o          : UART serial out, idle high (registered)
//   busy_o        : high while a report line is in flight (registered)
//   done_o        : one-cycle pulse after the final stop bit (registered)
module xilinx_exit_status_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 130
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W     = 3;
  localparam int unsigned CHAR_W    = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(14);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [CHAR_W-1:0]   char_q, char_d;
  logic [31:0]         value_q, value_d;
  logic                valid_q;
  logic                tx_d, busy_d, done_d;
  logic                trigger;
  logic                baud_tc;
  logic [7:0]          char_byte;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  // Character at position idx of the report line for value v.
  function automatic logic [7:0] line_char(input logic [CHAR_W-1:0] idx,
                                           input logic [31:0] v);
    case (idx)
      4'd0:    return 8'h45;  // 'E'
      4'd1:    return 8'h58;  // 'X'
      4'd2:    return 8'h49;  // 'I'
      4'd3:    return 8'h54;  // 'T'
      4'd4:    return 8'h3D;  // '='
      4'd5:    return hex_ascii(v[31:28]);
      4'd6:    return hex_ascii(v[27:24]);
      4'd7:    return hex_ascii(v[23:20]);
      4'd8:    return hex_ascii(v[19:16]);
      4'd9:    return hex_ascii(v[15:12]);
      4'd10:   return hex_ascii(v[11:8]);
      4'd11:   return hex_ascii(v[7:4]);
      4'd12:   return hex_ascii(v[3:0]);
      4'd13:   return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign trigger = exit_valid_i & ~valid_q;
  assign baud_tc = (baud_q == BAUD_LAST);

  // State and output registers.
  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      value_q <= value_d;
      valid_q <= exit_valid_i;
      tx_o    <= tx_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Next state, counters, and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    char_d    = char_q;
    value_d   = value_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    char_byte = 8'h00;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the previous line, so an edge
        // landing there is dropped.
        if (trigger && !done_o) begin
          state_d = START;
          value_d = exit_value_i;
          char_d  = '0;
          bit_d   = '0;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          if (char_q == CHAR_LAST) begin
            state_d = IDLE;
            char_d  = '0;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            char_d  = char_q + CHAR_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they register in step with it.
    char_byte = line_char(char_d, value_d);
    busy_d    = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = char_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_xilinx_exit_status_uart_tx.sv
// Scoreboard bench for xilinx_exit_status_uart_tx: stimulus pushes the
// expected report characters, a UART monitor decodes tx_o and pops/compares.
module tb_xilinx_exit_status_uart_tx;

  localparam int unsigned CPB     = 4;
  localparam int unsigned HALF    = CPB / 2;
  localparam int unsigned LINE_CY = 150 * CPB;

  logic        clk_gen;
  logic        rst_n;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];

  xilinx_exit_status_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_gen      (clk_gen),
    .rst_n        (rst_n),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_gen = 1'b0;
  always #5 clk_gen = ~clk_gen;

  always @(posedge clk_gen) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // UART monitor: samples mid-bit, pops one expected character per frame.
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  always @(negedge clk_gen) begin
    if (done_o === 1'b1) done_cnt++;
    if (!rst_n) begin
      mon_act = 1'b0;
      mon_cnt = 0;
    end else if (!mon_act) begin
      if (tx_o === 1'b0) begin
        mon_act = 1'b1;
        mon_cnt = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == HALF) begin
        chk("start_bit", 32'(tx_o), 32'd0);
      end else if (mon_cnt < HALF + 9 * CPB) begin
        if ((mon_cnt - HALF) % CPB == 0)
          mon_byte[(mon_cnt - HALF) / CPB - 1] = tx_o;
      end else if (mon_cnt == HALF + 9 * CPB) begin
        chk("stop_bit", 32'(tx_o), 32'd1);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL uart_byte: got unexpected byte %0h, expected none", mon_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (mon_byte !== e) begin
            failures++;
            $display("FAIL uart_byte: got %0h expected %0h (cycle %0d)", mon_byte, e, cyc);
          end
        end
        mon_act = 1'b0;
      end
    end
  end

  // Raise exit_valid_i at a negedge; returns the cycle stamp of the first line cycle.
  task automatic trigger_line(output int e_cyc);
    exit_valid_i = 1'b1;
    @(posedge clk_gen);
    @(negedge clk_gen);
    e_cyc = cyc;
    chk("start_latency_tx", 32'(tx_o), 32'd0);
    chk("start_latency_busy", 32'(busy_o), 32'd1);
  endtask

  // Wait (bounded) for done_o; optionally re-raise exit_valid_i in the done cycle.
  task automatic wait_done(input int e_cyc, input bit retrig);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < LINE_CY + 100) begin
      @(negedge clk_gen);
      n++;
    end
    chk("done_seen", 32'(done_o), 32'd1);
    chk("done_latency", 32'(cyc - e_cyc), 32'(LINE_CY));
    chk("done_busy_low", 32'(busy_o), 32'd0);
    chk("done_tx_idle", 32'(tx_o), 32'd1);
    if (retrig) exit_valid_i = 1'b1;
    @(negedge clk_gen);
    chk("done_one_cycle", 32'(done_o), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_gen);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int d0;
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = 32'h0;
    idle_cycles(3);
    rst_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_gen);
      chk("idle_tx", 32'(tx_o), 32'd1);
      chk("idle_busy", 32'(busy_o), 32'd0);
      chk("idle_done", 32'(done_o), 32'd0);
    end

    // 2: DEADBEEF
    exit_value_i = 32'hDEADBEEF;
    push_str("EXIT=DEADBEEF\r\n");
    d0 = done_cnt;
    trigger_line(e);
    wait_done(e, 1'b0);
    chk("q_empty_deadbeef", 32'(exp_q.size()), 32'd0);
    chk("done_count_deadbeef", 32'(done_cnt - d0), 32'd1);
    exit_valid_i = 1'b0;
    idle_cycles(5);

    // 3: all-zero value, then digit/letter boundary with a done-cycle edge
    exit_value_i = 32'h0;
    push_str("EXIT=00000000\r\n");
    trigger_line(e);
    exit_valid_i = 1'b0;
    wait_done(e, 1'b0);
    exit_value_i = 32'h0123ABCF;
    push_str("EXIT=0123ABCF\r\n");
    trigger_line(e);
    exit_valid_i = 1'b0;
    d0 = done_cnt;
    wait_done(e, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_gen);
      if (i % 10 == 0) chk("done_cycle_edge_ignored", 32'(busy_o), 32'd0);
    end
    chk("done_count_0123", 32'(done_cnt - d0), 32'd1);
    exit_valid_i = 1'b0;
    idle_cycles(5);

    // 4: toggling and value change during a line are ignored
    exit_value_i = 32'h5A5A0FF0;
    push_str("EXIT=5A5A0FF0\r\n");
    d0 = done_cnt;
    trigger_line(e);
    idle_cycles(100);
    exit_valid_i = 1'b0;
    idle_cycles(5);
    exit_value_i = 32'h1;
    exit_valid_i = 1'b1;
    idle_cycles(20);
    exit_valid_i = 1'b0;
    idle_cycles(7);
    exit_valid_i = 1'b1;
    wait_done(e, 1'b0);
    idle_cycles(LINE_CY + 50);
    chk("busy_no_second_line", 32'(busy_o), 32'd0);
    chk("done_count_toggle", 32'(done_cnt - d0), 32'd1);
    chk("q_empty_toggle", 32'(exp_q.size()), 32'd0);
    exit_valid_i = 1'b0;
    idle_cycles(5);

    // 5: reset during char 7, data bit 3; then a fresh line with valid held high
    exit_value_i = 32'h89ABCDEF;
    push_str("EXIT=89ABCDEF\r\n");
    trigger_line(e);
    idle_cycles(7 * 10 * CPB + 4 * CPB + HALF);
    rst_n = 1'b0;
    #1;
    chk("reset_tx_async", 32'(tx_o), 32'd1);
    chk("reset_busy_async", 32'(busy_o), 32'd0);
    exp_q.delete();
    idle_cycles(3);
    chk("reset_done_low", 32'(done_o), 32'd0);
    exit_value_i = 32'hFEDC3210;
    push_str("EXIT=FEDC3210\r\n");
    d0 = done_cnt;
    rst_n = 1'b1;
    @(posedge clk_gen);
    @(negedge clk_gen);
    e = cyc;
    chk("post_reset_start_tx", 32'(tx_o), 32'd0);
    chk("post_reset_busy", 32'(busy_o), 32'd1);
    wait_done(e, 1'b0);
    chk("q_empty_post_reset", 32'(exp_q.size()), 32'd0);

    // 6: level held for three line durations produces one line
    idle_cycles(2 * LINE_CY + 20);
    chk("held_busy_idle", 32'(busy_o), 32'd0);
    chk("held_tx_idle", 32'(tx_o), 32'd1);
    chk("held_done_count", 32'(done_cnt - d0), 32'd1);
    exit_valid_i = 1'b0;
    idle_cycles(5);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
